// File: rtl/float_pkg.sv
// Shared float/int conversion definitions: default widths, bias, class and
// rounding-mode encodings. Also used by the int-to-float block.
package float_pkg;
   localparam int E_BIT_D     = 8;
   localparam int F_BIT_D     = 23;
   localparam int INT_WIDTH_D = 32;
   localparam int E_REF_D     = 2**(E_BIT_D-1) - 1;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } f_class_t;

   localparam logic RND_TRUNC = 1'b0;
   localparam logic RND_RNE   = 1'b1;
endpackage

// File: rtl/float2int_pipe_shift.sv
// S2 barrel shifter: aligns {1,f} to the integer point, yielding magnitude,
// guard bit and sticky OR of the remaining fraction.
module f2i_shift
   import float_pkg::*;
#(
   parameter int F_BIT     = F_BIT_D,
   parameter int INT_WIDTH = INT_WIDTH_D,
   parameter int SH_W      = $clog2(INT_WIDTH+1)
)(
   input  logic [F_BIT:0]     i_mant,
   input  logic [SH_W-1:0]    i_shamt,
   input  logic               i_tiny,
   output logic [INT_WIDTH-1:0] o_mag,
   output logic               o_guard,
   output logic               o_sticky
);
   // i_shamt = u+1, so bit F_BIT of w_t is the guard position.
   logic [INT_WIDTH+F_BIT:0] w_t;

   assign w_t      = {{INT_WIDTH{1'b0}}, i_mant} << i_shamt;
   assign o_mag    = i_tiny ? '0   : w_t[INT_WIDTH+F_BIT:F_BIT+1];
   assign o_guard  = i_tiny ? 1'b0 : w_t[F_BIT];
   assign o_sticky = i_tiny ? |i_mant : |w_t[F_BIT-1:0];
endmodule

// File: rtl/float2int_pipe.sv
// Three-stage float to signed integer converter with truncate/RNE rounding,
// saturation and a single global stall enable.
module float2int_pipe
   import float_pkg::*;
#(
   parameter int E_BIT     = E_BIT_D,
   parameter int F_BIT     = F_BIT_D,
   parameter int INT_WIDTH = INT_WIDTH_D
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [E_BIT+F_BIT:0]   float_in,
   input  logic                   rnd_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INT_WIDTH-1:0]   int_out,
   output logic                   out_ovf,
   output logic                   out_invalid,
   output logic                   out_inexact
);
   localparam int E_REF = 2**(E_BIT-1) - 1;
   localparam int SH_W  = $clog2(INT_WIDTH+1);
   localparam logic [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};
   localparam logic [INT_WIDTH-1:0] INT_MAX = ~INT_MIN;

   logic                  w_en;
   logic                  w_s;
   logic [E_BIT-1:0]      w_e;
   logic [F_BIT-1:0]      w_f;
   logic signed [E_BIT+1:0] w_u;
   f_class_t              w_cls;
   logic [F_BIT:0]        w_mant;
   logic [SH_W-1:0]       w_shamt;
   logic                  w_tiny;

   logic                  r1_valid, r1_sign, r1_tiny, r1_rnd;
   f_class_t              r1_cls;
   logic [F_BIT:0]        r1_mant;
   logic [SH_W-1:0]       r1_shamt;

   logic [INT_WIDTH-1:0]  w_mag;
   logic                  w_guard, w_sticky;

   logic                  r2_valid, r2_sign, r2_rnd, r2_guard, r2_sticky;
   f_class_t              r2_cls;
   logic [INT_WIDTH-1:0]  r2_mag;

   logic                  w_inc, w_povf, w_novf;
   logic [INT_WIDTH:0]    w_rmag;
   logic [INT_WIDTH-1:0]  w_int;
   logic                  w_ovf, w_inv, w_inx;

   logic                  r_oval, r_ovf, r_inv, r_inx;
   logic [INT_WIDTH-1:0]  r_int;

   assign w_en     = out_ready | ~r_oval;
   assign in_ready = w_en;

   // S1: classify and compute the alignment shift
   assign w_s = float_in[E_BIT+F_BIT];
   assign w_e = float_in[E_BIT+F_BIT-1:F_BIT];
   assign w_f = float_in[F_BIT-1:0];
   assign w_u = $signed({2'b00, w_e}) - $signed((E_BIT+2)'(E_REF));

   always_comb begin
      w_cls   = CLS_NORM;
      w_mant  = {1'b1, w_f};
      w_shamt = '0;
      w_tiny  = 1'b0;
      if (w_e == '0) begin
         w_cls  = CLS_ZERO;
         w_mant = '0;
      end else if (&w_e) begin
         w_cls  = (w_f == '0) ? CLS_INF : CLS_NAN;
         w_mant = '0;
      end else if (int'(w_u) >= INT_WIDTH) begin
         // Out of range regardless of rounding: saturate like an infinity.
         w_cls  = CLS_INF;
         w_mant = '0;
      end else if (int'(w_u) < -1) begin
         w_tiny = 1'b1;
      end else begin
         w_shamt = SH_W'(int'(w_u) + 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_valid <= 1'b0;
         r1_sign  <= 1'b0;
         r1_tiny  <= 1'b0;
         r1_rnd   <= RND_TRUNC;
         r1_cls   <= CLS_ZERO;
         r1_mant  <= '0;
         r1_shamt <= '0;
      end else if (w_en) begin
         r1_valid <= in_valid;
         r1_sign  <= w_s;
         r1_tiny  <= w_tiny;
         r1_rnd   <= rnd_mode;
         r1_cls   <= w_cls;
         r1_mant  <= w_mant;
         r1_shamt <= w_shamt;
      end
   end

   f2i_shift #(
      .F_BIT     (F_BIT),
      .INT_WIDTH (INT_WIDTH),
      .SH_W      (SH_W)
   ) u_shift (
      .i_mant   (r1_mant),
      .i_shamt  (r1_shamt),
      .i_tiny   (r1_tiny),
      .o_mag    (w_mag),
      .o_guard  (w_guard),
      .o_sticky (w_sticky)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_valid  <= 1'b0;
         r2_sign   <= 1'b0;
         r2_rnd    <= RND_TRUNC;
         r2_guard  <= 1'b0;
         r2_sticky <= 1'b0;
         r2_cls    <= CLS_ZERO;
         r2_mag    <= '0;
      end else if (w_en) begin
         r2_valid  <= r1_valid;
         r2_sign   <= r1_sign;
         r2_rnd    <= r1_rnd;
         r2_guard  <= w_guard;
         r2_sticky <= w_sticky;
         r2_cls    <= r1_cls;
         r2_mag    <= w_mag;
      end
   end

   // S3: round, range-check after the carry, then negate or saturate
   assign w_inc  = (r2_rnd == RND_RNE) & r2_guard & (r2_sticky | r2_mag[0]);
   assign w_rmag = {1'b0, r2_mag} + (INT_WIDTH+1)'(w_inc);
   assign w_povf = w_rmag[INT_WIDTH] | w_rmag[INT_WIDTH-1];
   assign w_novf = w_rmag[INT_WIDTH] | (w_rmag[INT_WIDTH-1] & (|w_rmag[INT_WIDTH-2:0]));

   always_comb begin
      w_int = '0;
      w_ovf = 1'b0;
      w_inv = 1'b0;
      w_inx = 1'b0;
      case (r2_cls)
         CLS_NAN:  w_inv = 1'b1;
         CLS_INF: begin
            w_int = r2_sign ? INT_MIN : INT_MAX;
            w_ovf = 1'b1;
         end
         CLS_NORM: begin
            if (r2_sign ? w_novf : w_povf) begin
               w_int = r2_sign ? INT_MIN : INT_MAX;
               w_ovf = 1'b1;
            end else begin
               w_int = r2_sign ? (~w_rmag[INT_WIDTH-1:0] + 1'b1) : w_rmag[INT_WIDTH-1:0];
               w_inx = r2_guard | r2_sticky;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_oval <= 1'b0;
         r_int  <= '0;
         r_ovf  <= 1'b0;
         r_inv  <= 1'b0;
         r_inx  <= 1'b0;
      end else if (w_en) begin
         r_oval <= r2_valid;
         r_int  <= w_int;
         r_ovf  <= w_ovf;
         r_inv  <= w_inv;
         r_inx  <= w_inx;
      end
   end

   assign out_valid   = r_oval;
   assign int_out     = r_int;
   assign out_ovf     = r_ovf;
   assign out_invalid = r_inv;
   assign out_inexact = r_inx;
endmodule
